// File: rtl/dbus_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_CORE = 2'd1,
        GNT_SPI  = 2'd2
    } e_arb_state;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_SPI  = 1'b1
    } e_owner;

    localparam logic [3:0] SIZE_WORD = 4'b1111;

endpackage

// File: rtl/dbus_rd_tracker.sv
// Tracks outstanding bus reads as an RD_LAT-deep {valid, owner} shift pipe
// and steers the returning read-valid pulse to the master that issued it.
module dbus_rd_tracker
    import dbus_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   load_i,
    input  e_owner owner_i,
    output logic   core_rd_valid_o,
    output logic   spi_rd_valid_o
);

    logic [RD_LAT-1:0] valid_q, valid_d;
    logic [RD_LAT-1:0] owner_q, owner_d;

    // Shift the pipe by one stage per cycle, inserting the current grant at stage 0.
    always_comb begin
        valid_d    = valid_q;
        owner_d    = owner_q;
        valid_d[0] = load_i;
        owner_d[0] = owner_i;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            valid_d[i] = valid_q[i-1];
            owner_d[i] = owner_q[i-1];
        end
    end

    // Pipe registers; reset drops any return still in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= {RD_LAT{1'b0}};
            owner_q <= {RD_LAT{1'b0}};
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    // Decode the last stage into a per-owner valid pulse.
    always_comb begin
        core_rd_valid_o = 1'b0;
        spi_rd_valid_o  = 1'b0;
        if (valid_q[RD_LAT-1]) begin
            if (owner_q[RD_LAT-1] == OWN_SPI) begin
                spi_rd_valid_o = 1'b1;
            end else begin
                core_rd_valid_o = 1'b1;
            end
        end else begin
            core_rd_valid_o = 1'b0;
            spi_rd_valid_o  = 1'b0;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master (core, SPI loader) to one-slave data-bus arbiter. The SPI loader
// cannot retry, so it always wins and is granted exactly one cycle after request.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_core_i,
    output logic          gnt_core_o,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wr_data_i,
    input  logic [3:0]    core_size_i,
    input  logic          core_read_i,
    input  logic          core_write_i,
    output logic [DW-1:0] core_rd_data_o,
    output logic          core_rd_valid_o,
    input  logic          req_spi_i,
    output logic          gnt_spi_o,
    input  logic [AW-1:0] spi_addr_i,
    input  logic [DW-1:0] spi_wr_data_i,
    input  logic [3:0]    spi_size_i,
    input  logic          spi_read_i,
    input  logic          spi_write_i,
    output logic [DW-1:0] spi_rd_data_o,
    output logic          spi_rd_valid_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wr_data_o,
    output logic [3:0]    bus_size_o,
    output logic          bus_read_o,
    output logic          bus_write_o,
    input  logic [DW-1:0] bus_rd_data_i
);

    e_arb_state state_q, state_d;
    e_owner     rd_owner_s;

    // State register; the state is the grant for the current cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: SPI absolute priority; a core request in its own grant cycle is ignored.
    always_comb begin
        state_d = IDLE;
        if (req_spi_i) begin
            state_d = GNT_SPI;
        end else if (req_core_i && (state_q != GNT_CORE)) begin
            state_d = GNT_CORE;
        end else begin
            state_d = IDLE;
        end
    end

    // Output decode: grants and slave-side mux driven from the current state.
    always_comb begin
        gnt_core_o    = 1'b0;
        gnt_spi_o     = 1'b0;
        bus_addr_o    = {AW{1'b0}};
        bus_wr_data_o = {DW{1'b0}};
        bus_size_o    = 4'b0000;
        bus_read_o    = 1'b0;
        bus_write_o   = 1'b0;
        rd_owner_s    = OWN_CORE;
        case (state_q)
            GNT_CORE: begin
                gnt_core_o    = 1'b1;
                bus_addr_o    = core_addr_i;
                bus_wr_data_o = core_wr_data_i;
                bus_size_o    = core_size_i;
                bus_read_o    = core_read_i;
                bus_write_o   = core_write_i;
                rd_owner_s    = OWN_CORE;
            end
            GNT_SPI: begin
                gnt_spi_o     = 1'b1;
                bus_addr_o    = spi_addr_i;
                bus_wr_data_o = spi_wr_data_i;
                bus_size_o    = spi_size_i;
                bus_read_o    = spi_read_i;
                bus_write_o   = spi_write_i;
                rd_owner_s    = OWN_SPI;
            end
            default: begin
                gnt_core_o = 1'b0;
                gnt_spi_o  = 1'b0;
            end
        endcase
    end

    // Read data goes to both masters; each qualifies it with its own valid.
    assign core_rd_data_o = bus_rd_data_i;
    assign spi_rd_data_o  = bus_rd_data_i;

    dbus_rd_tracker #(
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .load_i          (bus_read_o),
        .owner_i         (rd_owner_s),
        .core_rd_valid_o (core_rd_valid_o),
        .spi_rd_valid_o  (spi_rd_valid_o)
    );

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
Two-master, one-slave arbiter for the on-chip data bus. It sits directly downstream of the SPI loader, consuming its req/gnt transactions, and arbitrates them against the CPU data port onto the single memory/peripheral bus. The SPI loader drives its transaction for exactly one cycle, only in the cycle after it raises its request, and never retries. The arbiter therefore guarantees the SPI master a grant exactly one cycle after its request.

Parameters:
AW, 32, address width
DW, 32, data width
RD_LAT, 1, slave read latency in cycles from the granted cycle to valid read data (1..3)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
req_core_i  in  1  core request; held high until granted
gnt_core_o  out  1  core grant; one-cycle pulse
core_addr_i  in  AW  core address, valid in grant cycle
core_wr_data_i  in  DW  core write data
core_size_i  in  4  core byte enables
core_read_i  in  1  core read strobe
core_write_i  in  1  core write strobe
core_rd_data_o  out  DW  read data returned to core
core_rd_valid_o  out  1  core read data valid
req_spi_i  in  1  SPI loader request; may be a one-cycle pulse
gnt_spi_o  out  1  SPI grant; one-cycle pulse
spi_addr_i / spi_wr_data_i / spi_size_i / spi_read_i / spi_write_i  in  AW/DW/4/1/1  SPI transaction, valid in grant cycle
spi_rd_data_o  out  DW  read data returned to SPI
spi_rd_valid_o  out  1  SPI read data valid
bus_addr_o / bus_wr_data_o / bus_size_o / bus_read_o / bus_write_o  out  AW/DW/4/1/1  slave-side transaction
bus_rd_data_i  in  DW  slave read data, valid RD_LAT cycles after the bus read

Behaviour:
- Reset values: all outputs are 0. FSM is in IDLE and the read-tracking pipe is cleared.
- FSM states are IDLE, GNT_CORE and GNT_SPI. The grant is registered, and the state equals the grant for the current cycle.
- Next-state rule, in priority order:
  - req_spi_i=1 -> GNT_SPI.
  - Else req_core_i=1 and the current state is not GNT_CORE -> GNT_CORE.
  - Else -> IDLE.
- SPI priority is absolute. gnt_spi_o is high in cycle t+1 whenever req_spi_i was high in cycle t, regardless of pending core requests.
- Core back-to-back: a request seen in the core's own grant cycle is ignored. Minimum core spacing is 2 cycles. The core holds req until gnt, so a losing core request simply waits.
- Core request simultaneous with an SPI request: SPI wins. The core is granted in the first later cycle with no SPI request.
- SPI request arriving in a GNT_CORE cycle: GNT_SPI follows next cycle and the core transaction completes normally.
- Bus mux (combinational from state):
  - GNT_CORE drives the core fields.
  - GNT_SPI drives the SPI fields.
  - IDLE drives all bus_* outputs to 0.
- A strobe from the granted master is forwarded unchanged. A granted cycle with read=write=0 is legal and produces no bus activity.
- Read return uses an RD_LAT-deep shift pipe of {valid, owner}, loaded in the grant cycle when bus_read_o=1.
  - At the pipe output, rd_valid pulses for exactly one cycle to the owner only.
  - bus_rd_data_i is routed to both *_rd_data_o ports; the ports are qualified by their rd_valid signals.
- Reads are independent of subsequent grants. Overlapping reads from alternating masters return in issue order.
- Reset mid-operation: the state, grant and read pipe clear immediately. A pending return is dropped and no rd_valid is emitted after reset release.
- No SPI request is ever lost. SPI requests spaced 1 cycle apart are each granted.

Decomposition:
- Package dbus_pkg holds:
  - typedef e_arb_state {IDLE, GNT_CORE, GNT_SPI}.
  - typedef e_owner {OWN_CORE, OWN_SPI}.
  - localparam SIZE_WORD = 4'b1111.
- One sub-module: dbus_rd_tracker, which implements the RD_LAT-deep valid/owner shift pipe and rd_valid decode.

Test Plan:
- Core only: req_core_i=1 held with write to addr 0x100, data 0xDEADBEEF -> gnt_core_o at t+1 only; bus_write_o=1, bus_addr_o=0x100, bus_wr_data_o=0xDEADBEEF, bus_size_o=4'hF in that cycle.
- SPI only: one-cycle req_spi_i pulse, write to addr 0x2000_0000, data 0x12345678 -> gnt_spi_o exactly at t+1; bus_* reflects the SPI fields in that cycle; IDLE the cycle after.
- Conflict: req_core_i and req_spi_i both high at t -> gnt_spi_o at t+1 and gnt_core_o at t+2; core req is held throughout and gnt_core_o never coincides with gnt_spi_o.
- SPI during core grant: core granted at t+1, SPI pulse at t+1 -> gnt_spi_o at t+2; both writes appear on the bus in order.
- Reads with RD_LAT=2: core read at cycle 5, SPI read at cycle 6; slave returns 0xAAAA0000 and 0xBBBB0000 -> core_rd_valid_o pulses at cycle 7 and spi_rd_valid_o at cycle 8 with the respective data; no cross-valid.
- Reset mid-read: core read granted, then rst_ni low for 1 cycle before the return -> all outputs 0 and no core_rd_valid_o pulse after release; a new core request is granted normally.
